// File: rtl/main_fsm.sv
// main_fsm: Moore control FSM sequencing multicycle ARM instructions (fetch..writeback).
// Latency: one state per clk; outputs decode the registered state only.
// Backpressure: none; advances every cycle, Op/Funct consulted only in DECODE and MEMADR.
module main_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = 0,
    DECODE   = 1,
    MEMADR   = 2,
    MEMRD    = 3,
    MEMWB    = 4,
    MEMWR    = 5,
    EXECUTER = 6,
    EXECUTEI = 7,
    ALUWB    = 8,
    BRANCH   = 9,
    UNKNOWN  = 10
  } state_t;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       mem_w;
    logic       reg_w;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Only the I and L/S bits of Funct steer sequencing; the rest belong to the ALU decoder.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // Bit order: next_pc, branch, mem_w, reg_w, ir_write, adr_src, result_src, alu_src_a, alu_src_b, alu_op
  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH:    ctrl = ctrl_t'(13'b1_0_0_0_1_0_10_01_10_0);
      DECODE:   ctrl = ctrl_t'(13'b0_0_0_0_0_0_10_01_10_0);
      EXECUTER: ctrl = ctrl_t'(13'b0_0_0_0_0_0_00_00_00_1);
      EXECUTEI: ctrl = ctrl_t'(13'b0_0_0_0_0_0_00_00_01_1);
      ALUWB:    ctrl = ctrl_t'(13'b0_0_0_1_0_0_00_00_00_0);
      MEMADR:   ctrl = ctrl_t'(13'b0_0_0_0_0_0_00_00_01_0);
      MEMWR:    ctrl = ctrl_t'(13'b0_0_1_0_0_1_00_00_00_0);
      MEMRD:    ctrl = ctrl_t'(13'b0_0_0_0_0_1_00_00_00_0);
      MEMWB:    ctrl = ctrl_t'(13'b0_0_0_1_0_0_01_00_00_0);
      BRANCH:   ctrl = ctrl_t'(13'b0_1_0_0_0_0_10_00_01_0);
      default:  ctrl = '0;
    endcase
  end

  assign NextPC    = ctrl.next_pc;
  assign Branch    = ctrl.branch;
  assign MemW      = ctrl.mem_w;
  assign RegW      = ctrl.reg_w;
  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign State     = state_q;

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Moore control FSM for the multicycle ARM datapath. It sequences each instruction through fetch, decode, execute, memory and writeback.
- It sits directly upstream of the conditional-execution logic. It produces the unconditioned RegW, MemW and Branch strobes that the conditional logic gates with CondEx, plus the datapath mux selects and the IR/PC enables.
- Op and Funct come from the instruction register, which is held stable between fetches.

Parameters:
- STATE_W, 4, width of the state encoding and of the State debug port (11 states used).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- Op  input  2  instruction op field [27:26]
- Funct  input  6  instruction funct field [25:20]; bit5 = I (immediate), bit0 = L/S
- IRWrite  output  1  instruction register load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result
- ALUSrcA  output  2  ALU A select: 00 = Rn, 01 = PC
- ALUSrcB  output  2  ALU B select: 00 = Rm/Src2, 01 = ExtImm, 10 = constant 4
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- NextPC  output  1  unconditional PC write (PC+4)
- RegW  output  1  register write request (pre-condition)
- MemW  output  1  memory write request (pre-condition)
- Branch  output  1  branch request (pre-condition)
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = ADD
- State  output  STATE_W  current state code, for debug and bench visibility

Behaviour:
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 are illegal and next-state to FETCH.
- Reset:
  - reset=0 at a rising edge forces state FETCH on that edge, overriding any transition, including mid-instruction (e.g. from MEMWR or ALUWB).
  - Outputs are a pure function of state, so after reset they equal the FETCH vector.
- Transitions (one state per clk):
  - FETCH -> DECODE
  - DECODE:
    - Op=00 & Funct[5]=0 -> EXECUTER
    - Op=00 & Funct[5]=1 -> EXECUTEI
    - Op=01 -> MEMADR
    - Op=10 -> BRANCH
    - Op=11 -> UNKNOWN
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR
  - MEMRD -> MEMWB
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB
  - MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN -> FETCH
- Op and Funct are sampled only in DECODE and MEMADR; their values in all other states are ignored.
- Output vector, in order {NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}:
  - FETCH 1,0,0,0,1,0,10,01,10,0
  - DECODE 0,0,0,0,0,0,10,01,10,0
  - EXECUTER 0,0,0,0,0,0,00,00,00,1
  - EXECUTEI 0,0,0,0,0,0,00,00,01,1
  - ALUWB 0,0,0,1,0,0,00,00,00,0
  - MEMADR 0,0,0,0,0,0,00,00,01,0
  - MEMWR 0,0,1,0,0,1,00,00,00,0
  - MEMRD 0,0,0,0,0,1,00,00,00,0
  - MEMWB 0,0,0,1,0,0,01,00,00,0
  - BRANCH 0,1,0,0,0,0,10,00,01,0
  - UNKNOWN all zero
- Cycle counts per instruction, FETCH inclusive:
  - data-processing 4
  - LDR 5
  - STR 4
  - B 3
  - undefined 3
- Strobe invariants:
  - RegW, MemW and Branch are each high for exactly one cycle per instruction of their class, and never high simultaneously.
  - IRWrite and NextPC are high only in FETCH.
- Outputs are registered-state Moore outputs: no combinational path from Op or Funct to any output.
- NoWrite and FlagW are not produced here; the ALU decoder owns them.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. Required: State=0, IRWrite=1, NextPC=1, ALUSrcB=10, ResultSrc=10. On the next edge State=1.
- ADD register form (Op=00, Funct=001000): State sequence 0,1,6,8,0. ALUOp=1 in EXECUTER. RegW=1 only in ALUWB with ResultSrc=00.
- LDR (Op=01, Funct=011001): State sequence 0,1,2,3,4,0. AdrSrc=1 in MEMRD. RegW=1 with ResultSrc=01 in MEMWB. MemW=0 throughout.
- STR (Op=01, Funct=011000), then B (Op=10): STR gives 0,1,2,5,0 with MemW=1 and AdrSrc=1 in MEMWR. B gives 0,1,9,0 with Branch=1, ALUSrcB=01 and ResultSrc=10.
- Undefined and robustness:
  - Op=11 -> states 0,1,10,0 with all outputs 0 in UNKNOWN.
  - Toggling Op/Funct in EXECUTER must not change that instruction's path.
- Mid-instruction reset: drive reset=0 while in MEMWR. On that edge State=0, and MemW drops to 0 in the following cycle.
